// File: rtl/instr_decode_pkg.sv
// Shared CPU definitions: opcode map, decoder FSM state encoding and call-stack geometry.
// Also used by the PC so both sides agree on the encoding.
package instr_decode_pkg;

    localparam int unsigned INSTR_W     = 16;
    localparam int unsigned OPC_W       = 5;
    localparam int unsigned SALTO_W     = 11;
    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned ALU_LIT_W   = 8;
    localparam int unsigned DEPTH_W     = 4;
    localparam int unsigned STACK_DEPTH = 8;

    localparam logic [OPC_W-1:0] OPC_NOP    = 5'b00000;
    localparam logic [OPC_W-1:0] OPC_GOTO   = 5'b00001;
    localparam logic [OPC_W-1:0] OPC_CALL   = 5'b00010;
    localparam logic [OPC_W-1:0] OPC_RETURN = 5'b00011;
    localparam logic [OPC_W-1:0] OPC_SKIPZ  = 5'b00100;
    localparam logic [OPC_W-1:0] OPC_SKIPNZ = 5'b00101;
    localparam logic [OPC_W-1:0] OPC_SKIPC  = 5'b00110;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    typedef struct packed {
        logic branch;
        logic enablestak;
        logic push;
        logic pop;
        logic flag;
        logic alu_en;
    } pc_ctrl_t;

endpackage

// File: rtl/call_depth_tracker.sv
// Call-nesting depth counter (0..STACK_DEPTH, saturating) with a sticky
// overflow/underflow error flag.
module call_depth_tracker
    import instr_decode_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               do_call,
    input  logic               do_ret,
    output logic [DEPTH_W-1:0] depth,
    output logic               stack_err,
    output logic               call_ok,
    output logic               ret_ok
);

    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;

    assign call_ok   = (depth_q < DEPTH_W'(STACK_DEPTH));
    assign ret_ok    = (depth_q != '0);
    assign depth     = depth_q;
    assign stack_err = err_q;

    // A rejected call/return leaves depth untouched and latches the error.
    always_comb begin
        depth_d = depth_q;
        err_d   = err_q;
        if (do_call) begin
            if (call_ok) depth_d = depth_q + DEPTH_W'(1);
            else         err_d   = 1'b1;
        end else if (do_ret) begin
            if (ret_ok) depth_d = depth_q - DEPTH_W'(1);
            else        err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: rtl/instr_decode.sv
// Zero-latency instruction decoder: PC-control strobes, ALU fields and a
// one-cycle squash of the word fetched behind any taken branch or skip.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INSTR_W-1:0]   instr,
    input  logic                 z_flag,
    input  logic                 c_flag,
    output logic [SALTO_W-1:0]   salto,
    output logic                 branch,
    output logic                 enablestak,
    output logic                 push,
    output logic                 pop,
    output logic                 flag,
    output logic                 alu_en,
    output logic [ALU_OP_W-1:0]  alu_op,
    output logic [ALU_LIT_W-1:0] alu_lit,
    output logic [DEPTH_W-1:0]   depth,
    output logic                 stack_err,
    output logic                 bubble
);

    logic [0:0]       state_q, state_d;
    logic [OPC_W-1:0] opcode;
    logic             run;
    logic             do_call, do_ret;
    logic             call_ok, ret_ok;
    pc_ctrl_t         ctrl;

    assign opcode  = instr[15:11];
    assign run     = (state_q == ST_RUN) && !reset;
    assign do_call = run && (opcode == OPC_CALL);
    assign do_ret  = run && (opcode == OPC_RETURN);

    call_depth_tracker u_depth (
        .clk       (clk),
        .reset     (reset),
        .do_call   (do_call),
        .do_ret    (do_ret),
        .depth     (depth),
        .stack_err (stack_err),
        .call_ok   (call_ok),
        .ret_ok    (ret_ok)
    );

    // Strobe decode; rejected calls/returns and reserved opcodes fall through as NOP.
    always_comb begin
        ctrl = '0;
        if (run) begin
            if (opcode[4]) begin
                ctrl.alu_en = 1'b1;
            end else begin
                case (opcode)
                    OPC_NOP: ;
                    OPC_GOTO: begin
                        ctrl.branch     = 1'b1;
                        ctrl.enablestak = 1'b1;
                    end
                    OPC_CALL: begin
                        ctrl.branch = call_ok;
                        ctrl.push   = call_ok;
                    end
                    OPC_RETURN: begin
                        ctrl.branch = ret_ok;
                        ctrl.pop    = ret_ok;
                    end
                    OPC_SKIPZ:  ctrl.flag = z_flag;
                    OPC_SKIPNZ: ctrl.flag = !z_flag;
                    OPC_SKIPC:  ctrl.flag = c_flag;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (ctrl.branch || ctrl.flag) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    assign salto      = instr[10:0];
    assign alu_op     = instr[14:11];
    assign alu_lit    = instr[7:0];
    assign branch     = ctrl.branch;
    assign enablestak = ctrl.enablestak;
    assign push       = ctrl.push;
    assign pop        = ctrl.pop;
    assign flag       = ctrl.flag;
    assign alu_en     = ctrl.alu_en;
    assign bubble     = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_instr_decode.sv
// Directed bench for instr_decode: expectations are queued as each word is
// driven and popped when the outputs are sampled mid-cycle.
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        z_flag, c_flag;
    logic [10:0] salto;
    logic        branch, enablestak, push, pop, flag, alu_en, stack_err, bubble;
    logic [3:0]  alu_op, depth;
    logic [7:0]  alu_lit;

    always #5 clk = ~clk;

    instr_decode dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .z_flag     (z_flag),
        .c_flag     (c_flag),
        .salto      (salto),
        .branch     (branch),
        .enablestak (enablestak),
        .push       (push),
        .pop        (pop),
        .flag       (flag),
        .alu_en     (alu_en),
        .alu_op     (alu_op),
        .alu_lit    (alu_lit),
        .depth      (depth),
        .stack_err  (stack_err),
        .bubble     (bubble)
    );

    // strobe vector order: {branch, enablestak, push, pop, flag, alu_en, bubble}
    localparam logic [6:0] S_NONE = 7'b0000000;
    localparam logic [6:0] S_GOTO = 7'b1100000;
    localparam logic [6:0] S_CALL = 7'b1010000;
    localparam logic [6:0] S_RET  = 7'b1001000;
    localparam logic [6:0] S_FLAG = 7'b0000100;
    localparam logic [6:0] S_ALU  = 7'b0000010;
    localparam logic [6:0] S_BUB  = 7'b0000001;

    localparam logic [15:0] W_NOP    = 16'h0000;
    localparam logic [15:0] W_GOTO   = 16'h0805;
    localparam logic [15:0] W_CALL   = 16'h1010;
    localparam logic [15:0] W_RET    = 16'h1800;
    localparam logic [15:0] W_SKIPZ  = 16'h2000;
    localparam logic [15:0] W_SKIPNZ = 16'h2800;
    localparam logic [15:0] W_SKIPC  = 16'h3000;
    localparam logic [15:0] W_RSVD   = 16'h3800;
    localparam logic [15:0] W_ALU    = 16'h8A3C;

    typedef struct packed {
        logic [6:0] s;
        logic [3:0] d;
        logic       e;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input logic [6:0] s, input logic [3:0] d, input logic e);
        exp_t x;
        x.s = s;
        x.d = d;
        x.e = e;
        sb_q.push_back(x);
    endtask

    task automatic check(input string tag);
        exp_t x;
        cmp({tag, "/sb_nonempty"}, 16'(sb_q.size() != 0), 16'd1);
        if (sb_q.size() != 0) begin
            x = sb_q.pop_front();
            cmp({tag, "/strobes"}, 16'({branch, enablestak, push, pop, flag, alu_en, bubble}), 16'(x.s));
            cmp({tag, "/depth"}, 16'(depth), 16'(x.d));
            cmp({tag, "/stack_err"}, 16'(stack_err), 16'(x.e));
        end
    endtask

    task automatic step(input logic [15:0] w, input logic z, input logic c,
                        input logic [6:0] s, input logic [3:0] d, input logic e,
                        input string tag);
        @(negedge clk);
        instr  = w;
        z_flag = z;
        c_flag = c;
        expect_out(s, d, e);
        #1;
        check(tag);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        instr  = W_NOP;
        reset  = 1'b1;
        expect_out(S_NONE, 4'd0, 1'b0);
        #1;
        check(tag);
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset  = 1'b1;
        instr  = W_GOTO;
        z_flag = 1'b0;
        c_flag = 1'b0;

        // Strobes held low while reset is high, even with a GOTO presented
        step(W_GOTO, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "reset_hold");
        cmp("salto_in_reset", 16'(salto), 16'h005);
        instr = W_NOP;
        reset = 1'b0;

        step(W_GOTO, 1'b0, 1'b0, S_GOTO, 4'd0, 1'b0, "goto");
        cmp("goto_salto", 16'(salto), 16'h005);
        step(W_GOTO, 1'b0, 1'b0, S_BUB, 4'd0, 1'b0, "goto_flush");

        // Return underflow
        step(W_RET, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "ret_underflow");
        step(W_NOP, 1'b0, 1'b0, S_NONE, 4'd0, 1'b1, "ret_underflow_err");
        reset_pulse("reset_clears_err");

        // Fill the call stack
        for (int i = 0; i < 8; i++) begin
            step(W_CALL, 1'b0, 1'b0, S_CALL, 4'(i), 1'b0, "call");
            cmp("call_salto", 16'(salto), 16'h010);
            step(W_NOP, 1'b0, 1'b0, S_BUB, 4'(i + 1), 1'b0, "call_flush");
        end
        step(W_CALL, 1'b0, 1'b0, S_NONE, 4'd8, 1'b0, "call_overflow");
        step(W_NOP, 1'b0, 1'b0, S_NONE, 4'd8, 1'b1, "call_overflow_err");
        step(W_RET, 1'b0, 1'b0, S_RET, 4'd8, 1'b1, "ret_from_full");
        step(W_NOP, 1'b0, 1'b0, S_BUB, 4'd7, 1'b1, "ret_flush_sticky");
        reset_pulse("reset_after_stack");

        // Skips
        step(W_SKIPZ, 1'b1, 1'b0, S_FLAG, 4'd0, 1'b0, "skipz_taken");
        step(W_NOP, 1'b0, 1'b0, S_BUB, 4'd0, 1'b0, "skipz_flush");
        step(W_SKIPZ, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "skipz_not_taken");
        step(W_NOP, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "skipz_no_bubble");
        step(W_SKIPNZ, 1'b0, 1'b0, S_FLAG, 4'd0, 1'b0, "skipnz_taken");
        step(W_NOP, 1'b0, 1'b0, S_BUB, 4'd0, 1'b0, "skipnz_flush");
        step(W_SKIPNZ, 1'b1, 1'b0, S_NONE, 4'd0, 1'b0, "skipnz_not_taken");
        step(W_SKIPC, 1'b0, 1'b1, S_FLAG, 4'd0, 1'b0, "skipc_taken");
        step(W_NOP, 1'b0, 1'b0, S_BUB, 4'd0, 1'b0, "skipc_flush");
        step(W_SKIPC, 1'b1, 1'b0, S_NONE, 4'd0, 1'b0, "skipc_not_taken");

        // ALU word and reserved opcode
        step(W_ALU, 1'b0, 1'b0, S_ALU, 4'd0, 1'b0, "alu");
        cmp("alu_op", 16'(alu_op), 16'h1);
        cmp("alu_lit", 16'(alu_lit), 16'h3C);
        step(W_NOP, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "alu_no_bubble");
        step(W_RSVD, 1'b0, 1'b0, S_NONE, 4'd0, 1'b0, "reserved_nop");

        // Reset mid-flush discards the squash and the call depth
        step(W_CALL, 1'b0, 1'b0, S_CALL, 4'd0, 1'b0, "call_before_rst");
        step(W_GOTO, 1'b0, 1'b0, S_BUB, 4'd1, 1'b0, "flush_before_rst");
        reset = 1'b1;
        #1;
        expect_out(S_NONE, 4'd0, 1'b0);
        check("rst_mid_flush");
        instr = W_NOP;
        reset = 1'b0;
        step(W_GOTO, 1'b0, 1'b0, S_GOTO, 4'd0, 1'b0, "goto_after_rst");
        step(W_NOP, 1'b0, 1'b0, S_BUB, 4'd0, 1'b0, "goto_after_rst_flush");

        cmp("sb_drained", 16'(sb_q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_decode.md
INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on the rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-003 SHALL: instr  input  16  program-ROM word for the current PC, valid one cycle after the PC presents the address.
REQ-004 SHALL: z_flag, c_flag  input  1 each  ALU zero/carry status, sampled in the cycle the skip instruction is decoded.
REQ-005 SHALL: salto  output  11  jump/call target, equal to instr[10:0].
REQ-006 SHALL: branch, enablestak, push, pop, flag  output  1 each  PC-control strobes (goto/call/return/skip).
REQ-007 SHALL: alu_en  output  1  ALU operation valid; alu_op  output  4  = instr[14:11]; alu_lit  output  8  = instr[7:0].
REQ-008 SHALL: depth  output  4  current call-nesting depth, 0..8.
REQ-009 SHALL: stack_err  output  1  sticky call-stack overflow/underflow indicator.
REQ-010 SHALL: bubble  output  1  high when the current instr is squashed.

Function
REQ-011 SHALL decode opcode instr[15:11]: 00000 NOP; 00001 GOTO; 00010 CALL; 00011 RETURN; 00100 SKIPZ; 00101 SKIPNZ; 00110 SKIPC; 1xxxx ALU; 00111-01111 reserved, decoded as NOP.
REQ-012 SHALL drive all outputs combinationally from instr, flags and registered state: zero-cycle decode latency.
REQ-013 SHALL, for GOTO: branch=1, enablestak=1, push=0, pop=0.
REQ-014 SHALL, for CALL with depth<8: branch=1, enablestak=0, push=1; depth increments at the next edge.
REQ-015 SHALL, for RETURN with depth>0: branch=1, enablestak=0, pop=1; depth decrements at the next edge.
REQ-016 SHALL assert flag for SKIPZ when z_flag=1, for SKIPNZ when z_flag=0, and for SKIPC when c_flag=1; otherwise flag=0.
REQ-017 SHALL, for ALU: alu_en=1 and all PC strobes at 0.
REQ-018 SHALL never assert push and pop together, and never assert push or pop without branch=1 and enablestak=0.
REQ-019 SHALL implement FSM {RUN, FLUSH}: RUN->FLUSH on any cycle with branch=1 or flag=1; FLUSH->RUN unconditionally after one cycle.
REQ-020 SHALL, in FLUSH: bubble=1; branch, enablestak, push, pop, flag and alu_en at 0; no depth change; instr ignored.
REQ-021 SHALL treat CALL at depth=8 as a NOP: no strobes, no depth change, no FLUSH; stack_err set at the next edge.
REQ-022 SHALL treat RETURN at depth=0 as a NOP: no strobes, no depth change, no FLUSH; stack_err set at the next edge.
REQ-023 SHALL hold stack_err at 1 until reset.
REQ-024 SHALL have depth saturate in 0..8; depth never wraps.
REQ-025 SHALL drive salto = instr[10:0] regardless of opcode; it is only meaningful when branch=1.

Reset
REQ-026 SHALL, on reset assertion: state=RUN, depth=0, stack_err=0, with bubble=0 immediately.
REQ-027 SHALL return the FSM to RUN if reset asserts mid-FLUSH; the pending squash is discarded.
REQ-028 SHALL hold all strobes and alu_en at 0 while reset is high.

Structure
REQ-029 SHALL take opcode constants, the {RUN, FLUSH} state enum and STACK_DEPTH=8 from the shared CPU package, which is also used by the PC.
REQ-030 SHALL place the depth counter and error logic in one sub-module, call_depth_tracker (inputs: do_call, do_ret; outputs: depth, stack_err, call_ok, ret_ok); everything else stays inline.

Verification
REQ-031 SHALL cover: reset, then instr=0x0805 (GOTO 0x005) -> branch=1, enablestak=1, salto=0x005; next cycle bubble=1 with all strobes 0.
REQ-032 SHALL cover: CALL 0x010 x8 (each separated by one flush cycle) -> depth=8; a 9th CALL -> no push, stack_err=1 next cycle, depth stays 8.
REQ-033 SHALL cover: RETURN at depth=0 after reset -> pop=0, branch=0, stack_err=1, bubble=0 next cycle.
REQ-034 SHALL cover: SKIPZ (0x2000) with z_flag=1 -> flag=1 then bubble; with z_flag=0 -> flag=0 and no bubble.
REQ-035 SHALL cover: ALU word 0x8A3C -> alu_en=1, alu_op=0x1, alu_lit=0x3C, PC strobes 0.
REQ-036 SHALL cover: reset pulsed during FLUSH after CALL (depth=1) -> depth=0, RUN, and the next GOTO is decoded normally.
